// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: captures every decoded field on each rising edge,
// with asynchronous clear and a synchronous bubble (flush) load.
module id_ex_stage_reg #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Reset_E,
  input  logic          RegWrite_D,
  input  logic [CW-1:0] ALU_SRC_D,
  input  logic          MemRead_D,
  input  logic [CW-1:0] ALUop_D,
  input  logic [RW-1:0] Rs_D,
  input  logic [RW-1:0] Rt_D,
  input  logic [RW-1:0] Dst_D,
  input  logic [DW-1:0] PC_D,
  input  logic [CW-1:0] MemtoReg_D,
  input  logic [DW-1:0] Read1_D,
  input  logic [DW-1:0] Read2_D,
  input  logic [1:0]    Tnew_D,
  input  logic [DW-1:0] Imm_D,
  input  logic [DW-1:0] PC8_D,
  output logic          RegWrite_E,
  output logic [CW-1:0] ALU_SRC_E,
  output logic          MemRead_E,
  output logic [CW-1:0] ALUop_E,
  output logic [RW-1:0] Rs_E,
  output logic [RW-1:0] Rt_E,
  output logic [RW-1:0] Dst_E,
  output logic [DW-1:0] PC_E,
  output logic [CW-1:0] MemtoReg_E,
  output logic [DW-1:0] Read1_E,
  output logic [DW-1:0] Read2_E,
  output logic [1:0]    Tnew_E,
  output logic [DW-1:0] Imm_E,
  output logic [DW-1:0] PC8_E
);

  localparam int TW = 1 + CW + 1 + CW + 3 * RW + DW + CW + DW + DW + 2 + DW + DW;

  logic [TW-1:0] w_d;
  logic [TW-1:0] r_q;

  assign w_d = {RegWrite_D, ALU_SRC_D, MemRead_D, ALUop_D, Rs_D, Rt_D, Dst_D,
                PC_D, MemtoReg_D, Read1_D, Read2_D, Tnew_D, Imm_D, PC8_D};

  // Stage register: async clear dominates, then bubble load, then capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= {TW{1'b0}};
    end else if (Reset_E) begin
      r_q <= {TW{1'b0}};
    end else begin
      r_q <= w_d;
    end
  end

  assign {RegWrite_E, ALU_SRC_E, MemRead_E, ALUop_E, Rs_E, Rt_E, Dst_E,
          PC_E, MemtoReg_E, Read1_E, Read2_E, Tnew_E, Imm_E, PC8_E} = r_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for the ID->EX stage register plus hand-written
// reset/flush corner sequences.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        regwrite;
    logic [3:0]  alu_src;
    logic        memread;
    logic [3:0]  aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] pc;
    logic [3:0]  memtoreg;
    logic [31:0] read1;
    logic [31:0] read2;
    logic [1:0]  tnew;
    logic [31:0] imm;
    logic [31:0] pc8;
  } bundle_t;

  typedef struct {
    logic    flush;
    bundle_t d;
    bundle_t e;
  } vec_t;

  logic        clk, reset, Reset_E;
  logic        RegWrite_D, MemRead_D, RegWrite_E, MemRead_E;
  logic [3:0]  ALU_SRC_D, ALUop_D, MemtoReg_D, ALU_SRC_E, ALUop_E, MemtoReg_E;
  logic [4:0]  Rs_D, Rt_D, Dst_D, Rs_E, Rt_E, Dst_E;
  logic [31:0] PC_D, Read1_D, Read2_D, Imm_D, PC8_D;
  logic [31:0] PC_E, Read1_E, Read2_E, Imm_E, PC8_E;
  logic [1:0]  Tnew_D, Tnew_E;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .Reset_E(Reset_E),
    .RegWrite_D(RegWrite_D), .ALU_SRC_D(ALU_SRC_D), .MemRead_D(MemRead_D),
    .ALUop_D(ALUop_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Dst_D(Dst_D), .PC_D(PC_D),
    .MemtoReg_D(MemtoReg_D), .Read1_D(Read1_D), .Read2_D(Read2_D),
    .Tnew_D(Tnew_D), .Imm_D(Imm_D), .PC8_D(PC8_D),
    .RegWrite_E(RegWrite_E), .ALU_SRC_E(ALU_SRC_E), .MemRead_E(MemRead_E),
    .ALUop_E(ALUop_E), .Rs_E(Rs_E), .Rt_E(Rt_E), .Dst_E(Dst_E), .PC_E(PC_E),
    .MemtoReg_E(MemtoReg_E), .Read1_E(Read1_E), .Read2_E(Read2_E),
    .Tnew_E(Tnew_E), .Imm_E(Imm_E), .PC8_E(PC8_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bundle_t b);
    RegWrite_D = b.regwrite; ALU_SRC_D = b.alu_src; MemRead_D = b.memread;
    ALUop_D = b.aluop; Rs_D = b.rs; Rt_D = b.rt; Dst_D = b.dst; PC_D = b.pc;
    MemtoReg_D = b.memtoreg; Read1_D = b.read1; Read2_D = b.read2;
    Tnew_D = b.tnew; Imm_D = b.imm; PC8_D = b.pc8;
  endtask

  function automatic bundle_t sample();
    bundle_t b;
    b.regwrite = RegWrite_E; b.alu_src = ALU_SRC_E; b.memread = MemRead_E;
    b.aluop = ALUop_E; b.rs = Rs_E; b.rt = Rt_E; b.dst = Dst_E; b.pc = PC_E;
    b.memtoreg = MemtoReg_E; b.read1 = Read1_E; b.read2 = Read2_E;
    b.tnew = Tnew_E; b.imm = Imm_E; b.pc8 = PC8_E;
    return b;
  endfunction

  task automatic chk(input string nm, input bundle_t exp);
    bundle_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  bundle_t ZERO, T1, T2, A, B, F31, ONES, prev;
  vec_t    tbl[9];

  initial begin
    ZERO = '0;
    T1 = '{regwrite:1'b1, alu_src:4'h3, memread:1'b1, aluop:4'h7, rs:5'd1,
           rt:5'd2, dst:5'd3, pc:32'h0000_3000, memtoreg:4'h1,
           read1:32'hDEAD_BEEF, read2:32'h1234_5678, tnew:2'd2,
           imm:32'hFFFF_FFF0, pc8:32'h0000_3008};
    T2 = '{regwrite:1'b1, alu_src:4'h0, memread:1'b0, aluop:4'd2, rs:5'd0,
           rt:5'd0, dst:5'd8, pc:32'h0000_3004, memtoreg:4'h0,
           read1:32'h0, read2:32'h0, tnew:2'd1, imm:32'h0, pc8:32'h0000_300C};
    A  = '{regwrite:1'b0, alu_src:4'hA, memread:1'b1, aluop:4'h5, rs:5'd10,
           rt:5'd21, dst:5'd0, pc:32'hAAAA_5555, memtoreg:4'h5,
           read1:32'h0F0F_0F0F, read2:32'hF0F0_F0F0, tnew:2'd3,
           imm:32'h8000_0001, pc8:32'h5555_AAAA};
    B  = '{regwrite:1'b1, alu_src:4'h5, memread:1'b0, aluop:4'hA, rs:5'd21,
           rt:5'd10, dst:5'd17, pc:32'h5555_AAAA, memtoreg:4'hA,
           read1:32'hF0F0_F0F0, read2:32'h0F0F_0F0F, tnew:2'd0,
           imm:32'h7FFF_FFFE, pc8:32'hAAAA_5555};
    F31 = T1;
    F31.regwrite = 1'b1; F31.memread = 1'b1; F31.dst = 5'd31;
    ONES = '1;

    tbl[0] = '{1'b0, T2,   T2};
    tbl[1] = '{1'b0, A,    A};
    tbl[2] = '{1'b0, B,    B};
    tbl[3] = '{1'b1, F31,  ZERO};
    tbl[4] = '{1'b0, A,    A};
    tbl[5] = '{1'b1, B,    ZERO};
    tbl[6] = '{1'b1, ONES, ZERO};
    tbl[7] = '{1'b0, B,    B};
    tbl[8] = '{1'b0, ONES, ONES};

    // Async reset between edges with nonzero inputs
    reset = 1'b0; Reset_E = 1'b0;
    drive(T1);
    #2 reset = 1'b1;
    #1 chk("reset_async_no_edge", ZERO);
    @(posedge clk); #1 chk("reset_held_over_edge", ZERO);

    @(negedge clk);
    reset = 1'b0;
    prev = ZERO;
    for (int i = 0; i < 9; i++) begin
      Reset_E = tbl[i].flush;
      drive(tbl[i].d);
      #1 chk($sformatf("hold_before_edge[%0d]", i), prev);
      @(posedge clk); #1 chk($sformatf("after_edge[%0d]", i), tbl[i].e);
      prev = tbl[i].e;
      @(negedge clk);
    end

    // Mid-cycle reset after a valid capture
    Reset_E = 1'b0; drive(A);
    @(posedge clk); #1 chk("capture_before_reset", A);
    #2 reset = 1'b1;
    #1 chk("reset_mid_cycle", ZERO);
    // reset with flush and with normal capture: reset dominates
    Reset_E = 1'b1; drive(ONES);
    @(posedge clk); #1 chk("reset_and_flush", ZERO);
    Reset_E = 1'b0;
    @(posedge clk); #1 chk("reset_over_capture", ZERO);
    // Release between edges: stays zero until next edge
    #2 reset = 1'b0; drive(B);
    #1 chk("released_before_edge", ZERO);
    @(posedge clk); #1 chk("capture_after_release", B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
